// File: rtl/motor_ramp_driver.sv
// rtl/motor_ramp_driver.sv - multi-channel slew-limited PWM H-bridge driver with reverse braking
module motor_ramp_driver #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int PWM_HZ        = 25_000,
    parameter int DUTY_W        = 10,
    parameter int CH            = 2,
    parameter int RAMP_STEP     = 8,
    parameter int BRAKE_PERIODS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 estop,
    input  logic [CH-1:0]        tgt_dir,
    input  logic [CH*DUTY_W-1:0] tgt_duty,
    output logic [2*CH-1:0]      in,
    output logic [CH-1:0]        pwm,
    output logic [CH-1:0]        busy,
    output logic [CH*DUTY_W-1:0] cur_duty,
    output logic                 period_tick
);

    localparam int CNT_MAX = CLK_HZ / PWM_HZ;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int PW      = CNT_W + DUTY_W + 1;
    localparam int BRK_W   = $clog2(BRAKE_PERIODS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DECEL = 2'd2;
    localparam logic [1:0] S_COAST = 2'd3;

    logic [CNT_W-1:0] cnt;

    // period_tick is registered, so it is raised one count early to line up with cnt==CNT_MAX-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= (cnt == CNT_W'(CNT_MAX - 1)) ? '0 : cnt + CNT_W'(1);
            period_tick <= (cnt == CNT_W'(CNT_MAX - 2));
        end
    end

    // One slew-limited step of cur toward g; the extra bit keeps the difference from wrapping
    function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] g);
        logic [DUTY_W:0] c;
        logic [DUTY_W:0] t;
        logic [DUTY_W:0] s;
        c = {1'b0, cur};
        t = {1'b0, g};
        s = (DUTY_W+1)'(RAMP_STEP);
        if (t >= c) begin
            return ((t - c) <= s) ? g : DUTY_W'(c + s);
        end else begin
            return ((c - t) <= s) ? g : DUTY_W'(c - s);
        end
    endfunction

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]        state;
        logic [1:0]        state_nxt;
        logic              dir_q;
        logic              dir_nxt;
        logic [DUTY_W-1:0] cur;
        logic [DUTY_W-1:0] cur_nxt;
        logic [DUTY_W-1:0] tgt;
        logic [BRK_W-1:0]  brake_cnt;
        logic [BRK_W-1:0]  brake_nxt;
        logic [PW-1:0]     thr;
        logic [1:0]        drive;
        logic [1:0]        in_q;
        logic              pwm_q;

        assign tgt = tgt_duty[i*DUTY_W +: DUTY_W];
        assign thr = (PW'(CNT_MAX) * PW'(cur)) >> DUTY_W;

        always_comb begin
            state_nxt = state;
            dir_nxt   = dir_q;
            cur_nxt   = cur;
            brake_nxt = brake_cnt;
            if (estop) begin
                state_nxt = S_IDLE;
                cur_nxt   = '0;
                brake_nxt = '0;
            end else if (period_tick) begin
                case (state)
                    S_IDLE: begin
                        if (tgt != '0) begin
                            dir_nxt   = tgt_dir[i];
                            state_nxt = S_RUN;
                        end
                    end
                    S_RUN: begin
                        // A reversal request wins over tracking the target at this tick
                        if (tgt_dir[i] != dir_q) begin
                            cur_nxt   = ramp_to(cur, '0);
                            state_nxt = S_DECEL;
                        end else begin
                            cur_nxt = ramp_to(cur, tgt);
                            if (tgt == '0 && cur_nxt == '0) begin
                                state_nxt = S_IDLE;
                            end
                        end
                    end
                    S_DECEL: begin
                        cur_nxt = ramp_to(cur, '0);
                        if (cur_nxt == '0) begin
                            state_nxt = S_COAST;
                            brake_nxt = BRK_W'(BRAKE_PERIODS);
                        end
                    end
                    default: begin
                        brake_nxt = brake_cnt - BRK_W'(1);
                        if (brake_cnt <= BRK_W'(1)) begin
                            state_nxt = S_IDLE;
                        end
                    end
                endcase
            end
        end

        always_comb begin
            drive = 2'b00;
            if (state_nxt == S_RUN || state_nxt == S_DECEL) begin
                drive = dir_nxt ? 2'b10 : 2'b01;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= S_IDLE;
                dir_q     <= 1'b1;
                cur       <= '0;
                brake_cnt <= '0;
                in_q      <= 2'b00;
                pwm_q     <= 1'b0;
            end else begin
                state     <= state_nxt;
                dir_q     <= dir_nxt;
                cur       <= cur_nxt;
                brake_cnt <= brake_nxt;
                in_q      <= drive;
                pwm_q     <= !estop && (PW'(cnt) < thr);
            end
        end

        assign in[2*i +: 2]              = in_q;
        assign pwm[i]                    = pwm_q;
        assign busy[i]                   = (state != S_IDLE);
        assign cur_duty[i*DUTY_W +: DUTY_W] = cur;
    end

endmodule
